// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared defaults, depth limit and occupancy-width helper for reg_pipe
package reg_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int MAX_DEPTH = 8;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid bit plus a WIDTH-bit data register; optional scan mux under REG_PIPE_SCAN_EN
module pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
`ifdef REG_PIPE_SCAN_EN
    input  logic             i_se,
    input  logic             i_si,
    output logic             o_so,
`endif
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

`ifdef REG_PIPE_SCAN_EN
    logic [WIDTH:0] w_chain;
    assign w_chain = {r_data, r_valid};
    assign o_so    = r_data[WIDTH-1];
`endif

    // Stage register: scan shift wins over the functional load; a bubble only clears valid
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
`ifdef REG_PIPE_SCAN_EN
        end else if (i_se) begin
            r_valid <= i_si;
            r_data  <= w_chain[WIDTH-1:0];
`endif
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage WIDTH-bit valid/ready register pipeline with bubble collapse and occupancy count
// Optional scan chain enabled by defining REG_PIPE_SCAN_EN.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      CLK,
    input  logic                      RST_N,
`ifdef REG_PIPE_SCAN_EN
    input  logic                      SE,
    input  logic                      SI,
    output logic                      SO,
`endif
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [WIDTH-1:0]          IN_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [WIDTH-1:0]          OUT_DATA,
    output logic [occ_w(DEPTH)-1:0]   OCC
);

    localparam int OW = occ_w(DEPTH);

    // Index i feeds stage i; index i+1 is the output of stage i.
    logic [DEPTH:0]   w_v;
    logic [WIDTH-1:0] w_d [DEPTH+1];
    logic [DEPTH:0]   w_ready;
    logic [OW-1:0]    w_pop;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [OW-1:0]    r_occ;

    assign w_v[0]         = IN_VALID;
    assign w_d[0]         = IN_DATA;
    assign w_ready[DEPTH] = OUT_READY;

`ifdef REG_PIPE_SCAN_EN
    logic [DEPTH:0] w_so;
    logic           r_scan_d;
    assign w_so[0] = SI;
    assign SO      = w_so[DEPTH];
`endif

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            assign w_ready[i] = !w_v[i+1] || w_ready[i+1];
            pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .CLK     (CLK),
                .RST_N   (RST_N),
`ifdef REG_PIPE_SCAN_EN
                .i_se    (SE),
                .i_si    (w_so[i]),
                .o_so    (w_so[i+1]),
`endif
                .i_load  (w_ready[i]),
                .i_valid (w_v[i]),
                .i_data  (w_d[i]),
                .o_valid (w_v[i+1]),
                .o_data  (w_d[i+1])
            );
        end
    endgenerate

`ifdef REG_PIPE_SCAN_EN
    assign IN_READY  = w_ready[0] && !SE;
    assign OUT_VALID = w_v[DEPTH] && !SE;
`else
    assign IN_READY  = w_ready[0];
    assign OUT_VALID = w_v[DEPTH];
`endif
    assign OUT_DATA   = w_d[DEPTH];
    assign OCC        = r_occ;
    assign w_in_xfer  = IN_VALID && IN_READY;
    assign w_out_xfer = OUT_VALID && OUT_READY;

    // Count of valid stages, used to resync the occupancy after scan and to check it
    always_comb begin
        w_pop = '0;
        for (int k = 1; k <= DEPTH; k++) w_pop = w_pop + OW'(w_v[k]);
    end

    // Occupancy tracks transfers; after a scan shift it restarts from the loaded valid bits
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_occ <= '0;
`ifdef REG_PIPE_SCAN_EN
            r_scan_d <= 1'b0;
        end else begin
            r_scan_d <= SE;
            if (!SE) r_occ <= (r_scan_d ? w_pop : r_occ) + OW'(w_in_xfer) - OW'(w_out_xfer);
        end
`else
        end else begin
            r_occ <= r_occ + OW'(w_in_xfer) - OW'(w_out_xfer);
        end
`endif
    end

    a_depth_supported: assert property (@(posedge CLK) DEPTH >= 1 && DEPTH <= MAX_DEPTH);

`ifdef REG_PIPE_SCAN_EN
    a_occ_popcount: assert property (@(posedge CLK) disable iff (!RST_N || SE || r_scan_d) r_occ == w_pop);
`else
    a_occ_popcount: assert property (@(posedge CLK) disable iff (!RST_N) r_occ == w_pop);
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: randomized and directed checks of reg_pipe against a word-position queue model
module tb_reg_pipe;

    localparam int W = 8;
    localparam int D = 4;
    localparam logic [W-1:0] RV = 8'hC3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [2:0]   occ;
`ifdef REG_PIPE_SCAN_EN
    logic         se = 1'b0;
    logic         si = 1'b0;
    logic         so;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit mdl_on = 0;

    always #5 clk = ~clk;

    reg_pipe #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VAL (RV)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
`ifdef REG_PIPE_SCAN_EN
        .SE        (se),
        .SI        (si),
        .SO        (so),
`endif
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_DATA   (in_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .OCC       (occ)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: ordered list of words in flight, oldest first, each with its stage position.
    // A word advances when the slot ahead is free after older words have moved.
    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } ent_t;

    ent_t q[$];

    always @(negedge clk) begin
        if (rst_n && mdl_on) begin
            ent_t n[$];
            bit   ov;
            bit   ir;
            n  = q;
            ov = q.size() > 0 && q[0].pos == D - 1;
            if (ov && out_ready) void'(n.pop_front());
            for (int k = 0; k < n.size(); k++)
                if (n[k].pos < D - 1 && (k == 0 || n[k-1].pos != n[k].pos + 1)) n[k].pos++;
            ir = n.size() == 0 || n[n.size()-1].pos != 0;
            chk("m_out_valid", int'(out_valid), int'(ov));
            if (ov) chk("m_out_data", int'(out_data), int'(q[0].d));
            chk("m_in_ready", int'(in_ready), int'(ir));
            chk("m_occ", int'(occ), q.size());
            if (in_valid && ir) n.push_back('{in_data, 0});
            q = n;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        bit acc;
        int pv;
        int pr;
        repeat (2) step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_occ", int'(occ), 0);
        chk("rst_out_data", int'(out_data), int'(RV));
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n  = 1'b1;
        mdl_on = 1;
        step();

        // Streaming 0x01..0x10 with the consumer always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = W'(i);
            step();
            if (i == 3) chk("stream_early", int'(out_valid), 0);
            if (i == 4) begin
                chk("stream_first_v", int'(out_valid), 1);
                chk("stream_first_d", int'(out_data), 1);
            end
            if (i >= 4) chk("stream_occ", int'(occ), 4);
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("stream_drained", int'(occ), 0);

        // Backpressure: only four of 0xA0..0xA5 fit while the consumer stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        nb = 0;
        for (int c = 0; c < 8; c++) begin
            in_data = 8'hA0 + W'(nb);
            acc = in_ready;
            step();
            if (acc) nb++;
        end
        chk("bp_accepted", nb, 4);
        chk("bp_occ", int'(occ), 4);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_head", int'(out_data), 8'hA0);
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = nb < 6;
            in_data  = 8'hA0 + W'(nb);
            acc = in_valid && in_ready;
            step();
            if (acc) nb++;
            if (c == 0) chk("bp_release", int'(out_data), 8'hA1);
        end
        chk("bp_total", nb, 6);
        chk("bp_drained", int'(occ), 0);

        // Bubble collapse: 0x55, two idle cycles, 0x66, consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        in_valid = 1'b1;
        in_data  = 8'h66;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("bub_occ", int'(occ), 2);
        chk("bub_in_ready", int'(in_ready), 1);
        chk("bub_head", int'(out_data), 8'h55);
        out_ready = 1'b1;
        step();
        chk("bub_next_v", int'(out_valid), 1);
        chk("bub_next_d", int'(out_data), 8'h66);
        step();
        chk("bub_empty", int'(occ), 0);

        // Full pass-through: one in and one out per cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hF0 + W'(i);
            step();
        end
        chk("pt_full", int'(occ), 4);
        chk("pt_blocked", int'(in_ready), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'hF4 + W'(i);
            step();
            chk("pt_occ", int'(occ), 4);
            chk("pt_in_ready", int'(in_ready), 1);
            chk("pt_data", int'(out_data), 8'hF1 + i);
        end
        in_valid = 1'b0;
        repeat (6) step();

        // Asynchronous reset in the middle of traffic with three words held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h31 + W'(i);
            step();
        end
        in_valid = 1'b0;
        chk("mid_occ3", int'(occ), 3);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_occ", int'(occ), 0);
        chk("mid_rst_data", int'(out_data), int'(RV));
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Randomized traffic in phases of varying load and backpressure
        for (int ph = 0; ph < 12; ph++) begin
            pv = $urandom_range(100, 5);
            pr = $urandom_range(100, 5);
            for (int c = 0; c < 250; c++) begin
                in_valid  = $urandom_range(99) < pv;
                out_ready = $urandom_range(99) < pr;
                in_data   = W'($urandom);
                step();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        chk("final_empty", int'(occ), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
Name: reg_pipe

Overview:
- Parametrised multi-bit successor to the single-bit dff cell: a DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits and valid/ready backpressure.
- Stages holding no data do not block upstream traffic, so empty stages (bubbles) collapse.
- Asynchronous active-low reset and an occupancy count.
- Used as the generic retiming/buffering element between datapath blocks built on the cell library.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  upstream presents IN_DATA.
- IN_READY  output  1  pipeline accepts IN_DATA this cycle.
- IN_DATA  input  WIDTH  upstream data.
- OUT_VALID  output  1  last stage holds valid data.
- OUT_READY  input  1  downstream accepts OUT_DATA this cycle.
- OUT_DATA  output  WIDTH  last-stage data register.
- OCC  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

Behaviour:
- Interface: one clock (CLK); reset is asynchronous and active-low (RST_N).
- Reset (RST_N=0, any time, including mid-transfer):
  - all valid bits clear immediately, without waiting for a clock edge;
  - all data registers load RESET_VAL;
  - OCC=0, OUT_VALID=0, OUT_DATA=RESET_VAL;
  - in-flight data is discarded.
- Reset release: first state change occurs on the first CLK rising edge after RST_N rises.
- Stage index: 0 = input side, DEPTH-1 = output side.
- Readiness: stage i is ready when it is not valid, or when stage i+1 is ready. The ready input of stage DEPTH-1 is OUT_READY; IN_READY is stage 0's ready.
  - This is a combinational ready chain across all stages; it is accepted up to DEPTH=8. Deeper instances are not supported.
- Stage update on each edge:
  - If stage i is ready: it loads the data and valid bit of stage i-1, or of IN_DATA/IN_VALID for i=0.
  - Otherwise it holds.
  - Data registers load only when the incoming valid is 1; a bubble leaves the data register unchanged and sets only valid=0.
- Transfers: input transfer = IN_VALID & IN_READY; output transfer = OUT_VALID & OUT_READY.
- Latency: a word accepted at edge k appears on OUT_DATA after edge k+DEPTH-1 when no stalls occur. Throughput is 1 word/cycle.
- Full pipeline (OCC=DEPTH) with OUT_READY=0: IN_READY=0 and all stages hold.
- Full pipeline with OUT_READY=1: IN_READY=1, so a word is accepted and one leaves in the same cycle; OCC stays DEPTH.
- Empty pipeline: OUT_VALID=0. OUT_DATA keeps the last-held value and is don't-care for the consumer.
- OCC update: OCC_next = OCC + in_xfer - out_xfer, registered. OCC must always equal the popcount of the valid bits; an assertion checks this.
- Data integrity: no word is dropped or duplicated, and order is preserved.

Optional Feature:
- Macro: REG_PIPE_SCAN_EN.
- When defined, the block adds ports SE (input, 1), SI (input, 1) and SO (output, 1).
- SE=1 (scan shift mode):
  - each edge shifts one serial chain SI -> valid[0] -> data[0][0..WIDTH-1] -> valid[1] -> ... -> data[DEPTH-1][WIDTH-1] -> SO;
  - IN_READY=0 and OUT_VALID=0 are forced;
  - OCC is held and is recomputed from the valid bits on the first edge with SE=0.
- SE=0: normal operation.
- Macro undefined: no scan ports and no scan muxes; behaviour is exactly as above.

Decomposition:
- Package reg_pipe_pkg holds:
  - default WIDTH/DEPTH constants;
  - occupancy-width function occ_w(depth) = $clog2(depth+1);
  - maximum supported DEPTH constant (8).
- Sub-module pipe_stage: one valid bit plus a WIDTH-bit register with async reset, load enable and optional scan mux, generated DEPTH times.

Test Plan:
- Reset: assert RST_N=0 mid-stream with OCC=3 and no clock edge -> OUT_VALID=0, OCC=0 and OUT_DATA=RESET_VAL immediately.
- Streaming: WIDTH=8, DEPTH=4, OUT_READY=1, push 0x01..0x10 back-to-back -> 0x01 out after the 3rd edge following its accept, then 1 word/cycle in order, OCC steady at 4 or below.
- Backpressure: OUT_READY=0 while pushing 0xA0..0xA5 -> only 4 accepted, IN_READY=0 after the 4th, OCC=4. Release OUT_READY -> 0xA0..0xA3 leave in order, then 0xA4 and 0xA5 are accepted.
- Bubble collapse: push 0x55, idle 2 cycles, push 0x66, with OUT_READY=0 -> both compact into stages 3 and 2, OCC=2, IN_READY stays 1.
- Full pass-through: pipeline full, IN_VALID=1 and OUT_READY=1 -> one accept and one output per cycle, OCC=4 constant.
- Scan (REG_PIPE_SCAN_EN): DEPTH=2, WIDTH=3, SE=1, shift in 8 bits 10110101 -> SO emits the prior chain contents. After SE=0, OCC equals the popcount of the loaded valid bits.
